// File: rtl/display_scan_ctrl_if.sv
// Display scan controller bus: the word handshake toward the upstream
// datapath plus the scan outputs toward the shared 7-segment decoder and
// the anode drivers.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic                  lz_blank;
  logic [3:0]            digit_code;
  logic                  digit_blank;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  // Upstream producer / display side.
  modport master (
    output data_in, data_valid, lz_blank,
    input  data_ready, digit_code, digit_blank, an, frame_tick
  );

  // The scan controller itself.
  modport slave (
    input  data_in, data_valid, lz_blank,
    output data_ready, digit_code, digit_blank, an, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Each digit slot is a blank
// (dead-time) phase followed by a show phase. A word accepted over the
// valid/ready handshake waits in a one-entry pending buffer and becomes
// the active word only at a frame boundary, so a frame is never torn.
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   bus
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [W-1:0]        active_q, active_d;
  logic [W-1:0]        pending_q, pending_d;
  logic                pend_full_q, pend_full_d;
  logic                lz_q, lz_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [3:0]          code_q, code_d;
  logic                blank_q, blank_d;
  logic                tick_q, tick_d;
  logic                ready_q, ready_d;

  logic [N_DIGITS-1:0] lz_mask;

  // Leading-zero mask: digit k blanks when nibbles k..top are all zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (active_q[4*k +: 4] == 4'h0);
      lz_mask[k] = lz_q && zero_above;
    end
  end

  // Next-state, slot sequencing, frame-boundary transfer and handshake.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    lz_d        = lz_q;
    an_d        = an_q;
    code_d      = code_q;
    blank_d     = blank_q;
    tick_d      = 1'b0;

    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          an_d    = ~(N_DIGITS'(1) << idx_q);
          code_d  = active_q[4*int'(idx_q) +: 4];
          blank_d = lz_mask[idx_q];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          an_d    = '1;
          blank_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            // Frame boundary: swap in the pending word and resample lz_blank.
            idx_d  = '0;
            tick_d = 1'b1;
            lz_d   = bus.lz_blank;
            if (pend_full_q) begin
              active_d    = pending_q;
              pend_full_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Capture needs the buffer empty; transfer needs it full, so they never collide.
    if (bus.data_valid && ready_q) begin
      pending_d   = bus.data_in;
      pend_full_d = 1'b1;
    end

    ready_d = !pend_full_d;
  end

  // State and registered outputs; reset blanks the display and drops any pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      lz_q        <= 1'b0;
      an_q        <= '1;
      code_q      <= 4'h0;
      blank_q     <= 1'b1;
      tick_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      lz_q        <= lz_d;
      an_q        <= an_d;
      code_q      <= code_d;
      blank_q     <= blank_d;
      tick_q      <= tick_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.digit_code  = code_q;
  assign bus.digit_blank = blank_q;
  assign bus.frame_tick  = tick_q;
  assign bus.data_ready  = ready_q;

endmodule
